// File: rtl/aes_round_controller.sv
// Purpose : sequencing FSM for the AES-128 encryption datapath (key expansion, round steps, handoff).
// Latency : first INIT cycle to transformer_done = 1 + 4*(NUM_ROUNDS-1) + 3 cycles (40 at default).
// Backpr. : transformer_done is held in DONE until output_read; input_ready is ignored unless IDLE.
//
// Ports:
//   clk, rst_         clock and asynchronous active-low reset
//   input_ready       level, plaintext + key available        -> input_ack, key_start (1-cycle pulses)
//   key_done          level, round keys valid (KEYEXP only)
//   load_state        load plaintext into the state register (INIT)
//   round             current round-key index 0..NUM_ROUNDS
//   sub_en/shift_en/mix_en/ark_en   round transformer step enables, one per cycle
//   transformer_done  level, ciphertext valid; cleared after output_read in DONE
//   busy              high in every state except IDLE
module aes_round_controller #(
  parameter int NUM_ROUNDS = 10,
  parameter int ROUND_W    = 4
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               input_ready,
  output logic               input_ack,
  output logic               key_start,
  input  logic               key_done,
  output logic               load_state,
  output logic [ROUND_W-1:0] round,
  output logic               sub_en,
  output logic               shift_en,
  output logic               mix_en,
  output logic               ark_en,
  output logic               transformer_done,
  input  logic               output_read,
  output logic               busy
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    IDLE, KEYEXP, INIT, SUB, SHIFT, MIX, ARK, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ROUND_W-1:0] round_d;
  logic               input_ack_d, key_start_d, load_state_d;
  logic               sub_en_d, shift_en_d, mix_en_d, ark_en_d;
  logic               done_d, busy_d;

  // State register; every output is a flop loaded from the decode of the
  // next state, so outputs always line up with the current state and no
  // input reaches an output without passing through a register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q          <= IDLE;
      round            <= '0;
      input_ack        <= 1'b0;
      key_start        <= 1'b0;
      load_state       <= 1'b0;
      sub_en           <= 1'b0;
      shift_en         <= 1'b0;
      mix_en           <= 1'b0;
      ark_en           <= 1'b0;
      transformer_done <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state_q          <= state_d;
      round            <= round_d;
      input_ack        <= input_ack_d;
      key_start        <= key_start_d;
      load_state       <= load_state_d;
      sub_en           <= sub_en_d;
      shift_en         <= shift_en_d;
      mix_en           <= mix_en_d;
      ark_en           <= ark_en_d;
      transformer_done <= done_d;
      busy             <= busy_d;
    end
  end

  // Next-state and round-index logic.
  always_comb begin
    state_d = state_q;
    round_d = round;
    unique case (state_q)
      IDLE: begin
        if (input_ready) begin
          state_d = KEYEXP;
          round_d = '0;
        end
      end
      KEYEXP: if (key_done) state_d = INIT;
      INIT: begin
        state_d = SUB;
        round_d = ROUND_W'(1);
      end
      SUB:   state_d = SHIFT;
      // Final round has no MixColumns.
      SHIFT: state_d = (round == LAST_ROUND) ? ARK : MIX;
      MIX:   state_d = ARK;
      ARK: begin
        if (round < LAST_ROUND) begin
          state_d = SUB;
          round_d = round + ROUND_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        // A simultaneous input_ready is not looked at here; it is
        // picked up from IDLE one cycle later.
        if (output_read) begin
          state_d = IDLE;
          round_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
      end
    endcase
  end

  // Output decode, registered above.
  always_comb begin
    input_ack_d  = (state_q == IDLE) && input_ready;
    key_start_d  = (state_q == IDLE) && input_ready;
    load_state_d = (state_d == INIT);
    sub_en_d     = (state_d == SUB);
    shift_en_d   = (state_d == SHIFT);
    mix_en_d     = (state_d == MIX);
    ark_en_d     = (state_d == INIT) || (state_d == ARK);
    done_d       = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

endmodule

// File: tb/tb_aes_round_controller.sv
module tb_aes_round_controller;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       input_ready = 1'b0;
  logic       key_done = 1'b0;
  logic       output_read = 1'b0;
  logic       input_ack, key_start, load_state;
  logic [3:0] round;
  logic       sub_en, shift_en, mix_en, ark_en, transformer_done, busy;

  int checks = 0;
  int failures = 0;

  // {ack, key_start, load, sub, shift, mix, ark, done, busy, round[3:0]}
  logic [12:0] obs;
  assign obs = {input_ack, key_start, load_state, sub_en, shift_en, mix_en,
                ark_en, transformer_done, busy, round};

  logic [12:0] trace [0:40];
  bit          cap_timeout;

  aes_round_controller #(.NUM_ROUNDS(10), .ROUND_W(4)) dut (
    .clk              (clk),
    .rst_             (rst_),
    .input_ready      (input_ready),
    .input_ack        (input_ack),
    .key_start        (key_start),
    .key_done         (key_done),
    .load_state       (load_state),
    .round            (round),
    .sub_en           (sub_en),
    .shift_en         (shift_en),
    .mix_en           (mix_en),
    .ark_en           (ark_en),
    .transformer_done (transformer_done),
    .output_read      (output_read),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected observation k cycles after the first load_state cycle.
  function automatic logic [12:0] exp_vec(input int k);
    logic [12:0] v;
    int r, ph;
    v    = '0;
    v[4] = 1'b1;
    if (k == 0) begin
      v[10] = 1'b1; v[6] = 1'b1;
    end else if (k <= 36) begin
      r  = (k - 1) / 4 + 1;
      ph = (k - 1) % 4;
      v[3:0] = 4'(r);
      case (ph)
        0:       v[9] = 1'b1;
        1:       v[8] = 1'b1;
        2:       v[7] = 1'b1;
        default: v[6] = 1'b1;
      endcase
    end else begin
      v[3:0] = 4'd10;
      if (k == 37)      v[9] = 1'b1;
      else if (k == 38) v[8] = 1'b1;
      else if (k == 39) v[6] = 1'b1;
      else              v[5] = 1'b1;
    end
    return v;
  endfunction

  // Pulse input_ready, then raise key_done kd cycles later.
  task automatic launch(input int kd, input bit hold_ready);
    input_ready = 1'b1;
    tick();
    if (!hold_ready) input_ready = 1'b0;
    repeat (kd) tick();
    key_done = 1'b1;
  endtask

  // Wait (bounded) for load_state, then record 41 cycles. At trace index
  // collide_k both input_ready and output_read are raised for one edge.
  task automatic capture(input int collide_k);
    cap_timeout = 1'b0;
    for (int i = 0; i < 60 && load_state !== 1'b1; i++) tick();
    if (load_state !== 1'b1) cap_timeout = 1'b1;
    trace[0] = obs;
    for (int k = 1; k <= 40; k++) begin
      if (k == collide_k) begin
        input_ready = 1'b1; output_read = 1'b1;
      end else if (k == collide_k + 1) begin
        input_ready = 1'b0; output_read = 1'b0;
      end
      tick();
      trace[k] = obs;
    end
  endtask

  task automatic release_block();
    output_read = 1'b1;
    tick();
    output_read = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", obs, 13'h0);
    end
    rst_ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs !== 13'h0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d got=%h exp=%h", i, obs, 13'h0);
      end
    end
  endtask

  task automatic test_nominal();
    int n_ark, n_sub, n_shift, n_mix, n_load, mix_last;
    bit held;
    input_ready = 1'b1;
    tick();
    checks++;
    if ({input_ack, key_start, busy} !== 3'b111) begin
      failures++;
      $display("FAIL nominal_ack got=%b exp=111", {input_ack, key_start, busy});
    end
    input_ready = 1'b0;
    tick();
    checks++;
    if ({input_ack, key_start, busy, load_state} !== 4'b0010) begin
      failures++;
      $display("FAIL nominal_ack_pulse got=%b exp=0010",
               {input_ack, key_start, busy, load_state});
    end
    repeat (3) tick();
    key_done = 1'b1;
    capture(-10);
    key_done = 1'b0;
    checks++;
    if (cap_timeout) begin
      failures++;
      $display("FAIL nominal_load_timeout got=0 exp=1");
    end
    n_ark = 0; n_sub = 0; n_shift = 0; n_mix = 0; n_load = 0; mix_last = 0;
    for (int k = 0; k <= 40; k++) begin
      checks++;
      if (trace[k] !== exp_vec(k)) begin
        failures++;
        $display("FAIL nominal_trace k=%0d got=%h exp=%h", k, trace[k], exp_vec(k));
      end
      n_load  += int'(trace[k][10]);
      n_sub   += int'(trace[k][9]);
      n_shift += int'(trace[k][8]);
      n_mix   += int'(trace[k][7]);
      n_ark   += int'(trace[k][6]);
      if (trace[k][7] && trace[k][3:0] == 4'd10) mix_last++;
    end
    checks++;
    if (n_ark !== 11 || n_sub !== 10 || n_shift !== 10 || n_mix !== 9 || n_load !== 1) begin
      failures++;
      $display("FAIL nominal_counts got=%0d/%0d/%0d/%0d/%0d exp=11/10/10/9/1",
               n_ark, n_sub, n_shift, n_mix, n_load);
    end
    checks++;
    if (mix_last !== 0) begin
      failures++;
      $display("FAIL nominal_mix_last got=%0d exp=0", mix_last);
    end
    held = 1'b1;
    repeat (15) begin
      tick();
      if (transformer_done !== 1'b1) held = 1'b0;
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL nominal_done_hold got=0 exp=1");
    end
    release_block();
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL nominal_release got=%h exp=%h", obs, 13'h0);
    end
  endtask

  task automatic test_backpressure();
    int bad_hold, bad_ack;
    launch(2, 1'b0);
    capture(-10);
    key_done = 1'b0;
    checks++;
    if (trace[40] !== exp_vec(40)) begin
      failures++;
      $display("FAIL bp_reach_done got=%h exp=%h", trace[40], exp_vec(40));
    end
    bad_hold = 0;
    repeat (50) begin
      tick();
      if (transformer_done !== 1'b1 || round !== 4'd10) bad_hold++;
    end
    checks++;
    if (bad_hold !== 0) begin
      failures++;
      $display("FAIL bp_hold bad_cycles=%0d exp=0", bad_hold);
    end
    input_ready = 1'b1;
    bad_ack = 0;
    repeat (5) begin
      tick();
      if (input_ack !== 1'b0 || key_start !== 1'b0 || transformer_done !== 1'b1) bad_ack++;
    end
    input_ready = 1'b0;
    checks++;
    if (bad_ack !== 0) begin
      failures++;
      $display("FAIL bp_no_ack bad_cycles=%0d exp=0", bad_ack);
    end
    release_block();
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL bp_release got=%h exp=%h", obs, 13'h0);
    end
  endtask

  task automatic test_busy_collision();
    launch(4, 1'b0);
    capture(14);
    key_done = 1'b0;
    checks++;
    if (cap_timeout) begin
      failures++;
      $display("FAIL collide_load_timeout got=0 exp=1");
    end
    for (int k = 0; k <= 40; k++) begin
      checks++;
      if (trace[k] !== exp_vec(k)) begin
        failures++;
        $display("FAIL collide_trace k=%0d got=%h exp=%h", k, trace[k], exp_vec(k));
      end
    end
    release_block();
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL collide_release got=%h exp=%h", obs, 13'h0);
    end
  endtask

  task automatic test_reset_mid();
    launch(1, 1'b0);
    for (int i = 0; i < 60 && round !== 4'd5; i++) tick();
    key_done = 1'b0;
    checks++;
    if (round !== 4'd5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_reach_r5 got=%0d exp=5", round);
    end
    #3;
    rst_ = 1'b0;
    #1;
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL rstmid_async got=%h exp=%h", obs, 13'h0);
    end
    repeat (2) tick();
    input_ready = 1'b1;
    rst_ = 1'b1;
    tick();
    checks++;
    if ({input_ack, key_start, round} !== 6'b110000) begin
      failures++;
      $display("FAIL rstmid_ack got=%b exp=110000", {input_ack, key_start, round});
    end
    input_ready = 1'b0;
    repeat (2) tick();
    key_done = 1'b1;
    capture(-10);
    key_done = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      checks++;
      if (trace[k] !== exp_vec(k)) begin
        failures++;
        $display("FAIL rstmid_trace k=%0d got=%h exp=%h", k, trace[k], exp_vec(k));
      end
    end
    release_block();
  endtask

  task automatic test_back_to_back();
    logic [12:0] first [0:40];
    key_done = 1'b0;
    launch(3, 1'b1);
    capture(-10);
    for (int k = 0; k <= 40; k++) first[k] = trace[k];
    for (int k = 0; k <= 40; k++) begin
      checks++;
      if (first[k] !== exp_vec(k)) begin
        failures++;
        $display("FAIL b2b_first_trace k=%0d got=%h exp=%h", k, first[k], exp_vec(k));
      end
    end
    // key_done stays high: the second KEYEXP lasts a single cycle.
    release_block();
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL b2b_idle_gap got=%h exp=%h", obs, 13'h0);
    end
    tick();
    input_ready = 1'b0;
    checks++;
    if ({input_ack, key_start, busy, load_state} !== 4'b1110) begin
      failures++;
      $display("FAIL b2b_second_ack got=%b exp=1110",
               {input_ack, key_start, busy, load_state});
    end
    tick();
    checks++;
    if ({input_ack, load_state, ark_en} !== 3'b011) begin
      failures++;
      $display("FAIL b2b_keyexp_1cycle got=%b exp=011", {input_ack, load_state, ark_en});
    end
    capture(-10);
    key_done = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      checks++;
      if (trace[k] !== first[k]) begin
        failures++;
        $display("FAIL b2b_second_trace k=%0d got=%h exp=%h", k, trace[k], first[k]);
      end
    end
    release_block();
    checks++;
    if (obs !== 13'h0) begin
      failures++;
      $display("FAIL b2b_release got=%h exp=%h", obs, 13'h0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_busy_collision();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_round_controller.md
Name: aes_round_controller

Overview:
- Sequencing FSM for the AES-128 encryption datapath. It accepts a block from the input interface and starts key expansion.
- It then drives the round transformer's step enables (SubBytes, ShiftRows, MixColumns, AddRoundKey) with the round index, one step per cycle.
- When the last round finishes it raises transformer_done to the output interface. It holds that until output_read confirms the ciphertext has been streamed out.

Parameters:
- NUM_ROUNDS, 10, number of full AES rounds; the last round omits MixColumns.
- ROUND_W, 4, width of the round index; must satisfy 2**ROUND_W > NUM_ROUNDS.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_  input  1  asynchronous, active-low reset.
- input_ready  input  1  level; input interface holds a complete plaintext and key.
- input_ack  output  1  one-cycle pulse; block accepted, input interface may clear.
- key_start  output  1  one-cycle pulse; starts key expansion.
- key_done  input  1  level; all round keys are valid.
- load_state  output  1  load plaintext into the state register.
- round  output  ROUND_W  current round-key index, 0..NUM_ROUNDS.
- sub_en  output  1  apply SubBytes this cycle.
- shift_en  output  1  apply ShiftRows this cycle.
- mix_en  output  1  apply MixColumns this cycle.
- ark_en  output  1  apply AddRoundKey with round key [round] this cycle.
- transformer_done  output  1  level; ciphertext valid on the state register.
- output_read  input  1  output interface has finished reading the ciphertext.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: while rst_=0, state=IDLE and round=0. All outputs are 0, including input_ack, key_start, every enable, transformer_done and busy. Reset takes effect immediately, including mid-round; the partial block is discarded.
- All outputs are registered and decoded from the state; there are no combinational input-to-output paths.
- States: IDLE, KEYEXP, INIT, SUB, SHIFT, MIX, ARK, DONE.
- IDLE, input_ready=1: input_ack=1 and key_start=1 for exactly the next cycle; go to KEYEXP.
- KEYEXP: wait; key_done is sampled only in this state. On key_done=1 go to INIT. There is no timeout.
- INIT (1 cycle): load_state=1, ark_en=1, round=0. Next: SUB with round=1.
- SUB -> SHIFT -> MIX -> ARK, each 1 cycle, with exactly one enable high per cycle.
- SHIFT: if round==NUM_ROUNDS, skip MIX and go straight to ARK.
- ARK: if round<NUM_ROUNDS, increment round and go to SUB. Otherwise go to DONE; round stays at NUM_ROUNDS.
- DONE: transformer_done=1, held until output_read=1 is sampled. Then go to IDLE, with round=0 and transformer_done=0 on the next cycle.
- Latency from first INIT cycle to first transformer_done cycle: 1 + 4*(NUM_ROUNDS-1) + 3 = 40 cycles at default.
- Enable counts per block at default: ark_en=11, sub_en=10, shift_en=10, mix_en=9, load_state=1.
- input_ready while busy: ignored, no ack. It is accepted only once back in IDLE.
- output_read outside DONE: ignored.
- input_ready and output_read both high in DONE: go to IDLE only. The new block is acked one cycle later, at the earliest in the second cycle after leaving DONE.
- key_done already high when KEYEXP is entered: proceed to INIT on the next edge (KEYEXP lasts 1 cycle).

Test Plan:
- Reset values: hold rst_=0 for 3 cycles -> all outputs 0, round=0. Release and hold all inputs 0 for 10 cycles -> outputs stay 0.
- Nominal block, NUM_ROUNDS=10: raise input_ready; key_done=1 five cycles after key_start; output_read pulsed 16 cycles after transformer_done.
  - input_ack and key_start each high exactly 1 cycle.
  - transformer_done rises exactly 40 cycles after load_state.
  - Enable counts 11/10/10/9.
  - No mix_en while round=10.
- Back-pressure: hold output_read=0 for 50 cycles in DONE -> transformer_done stays 1 and round stays 10. A further input_ready gets no input_ack.
- Busy collision: pulse input_ready during round 4 -> no input_ack, and the sequence timing is unchanged.
- Reset mid-operation: assert rst_=0 asynchronously between clock edges during round 5 -> all outputs 0 immediately. After release with input_ready=1, the next block runs a full 40-cycle sequence from round 0.
- Back-to-back: input_ready held high and output_read asserted in DONE -> IDLE for 1 cycle, then input_ack for the second block. The second block's enable trace is identical to the first.
